clint: RTL and testbench

Core-local interruptor for the RISu64 core: memory-mapped machine software-interrupt bit, 64-bit `mtime` counter and `mtimecmp` compare register. It drives the level interrupt inputs `extint_software` and `extint_timer` of the trap/CSR unit, which samples their rising edges into `mip`. It sits on the core's uncached MMIO path as a single-outstanding request/response slave.

---
 rtl/clint_pkg.sv | 16 +
 rtl/clint_if.sv | 18 +
 rtl/clint_timer.sv | 37 +++
 rtl/clint.sv | 84 ++++++++
 tb/tb_clint.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/clint_pkg.sv
// clint_pkg: shared CLINT offsets, bus FSM states, reset constants and byte-merge helper.
package clint_pkg;
  localparam logic [15:0] CLINT_MSIP     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP = 16'h4000;
  localparam logic [15:0] CLINT_MTIME    = 16'hBFF8;
  localparam logic [63:0] MTIMECMP_RST   = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {ST_IDLE, ST_RESP} state_e;

  function automatic logic [63:0] byte_merge(input logic [63:0] old_v, input logic [63:0] wdata,
                                             input logic [7:0] wmask);
    byte_merge = old_v;
    for (int i = 0; i < 8; i++)
      if (wmask[i]) byte_merge[8*i +: 8] = wdata[8*i +: 8];
  endfunction
endpackage

// File: rtl/clint_if.sv
// clint_if: single-outstanding MMIO request/response bus between the core and the CLINT.
interface clint_if;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        req_wen;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        resp_valid;
  logic        resp_ready;

  modport slave(input req_addr, req_wdata, req_wmask, req_wen, req_valid, resp_ready,
                output req_ready, resp_rdata, resp_err, resp_valid);
  modport master(output req_addr, req_wdata, req_wmask, req_wen, req_valid, resp_ready,
                 input req_ready, resp_rdata, resp_err, resp_valid);
endinterface

// File: rtl/clint_timer.sv
// clint_timer: prescaled 64-bit mtime counter with a byte-merged bus write port.
module clint_timer
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_i,
  input  logic [63:0] wdata_i,
  input  logic [7:0]  wmask_i,
  output logic [63:0] mtime_o,
  output logic [63:0] mtime_d_o
);
  logic [31:0] presc_q, presc_d;
  logic [63:0] mtime_q;
  logic        tick;

  // written bytes override the incremented value, unwritten bytes keep the tick
  always_comb begin
    tick      = presc_q == TICK_DIV - 1;
    presc_d   = tick ? '0 : presc_q + 1;
    mtime_d_o = byte_merge(mtime_q + 64'(tick), wdata_i, wr_i ? wmask_i : 8'h00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      mtime_q <= '0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d_o;
    end
  end

  assign mtime_o = mtime_q;
endmodule

// File: rtl/clint.sv
// clint: core-local interruptor with msip, mtime and mtimecmp behind a single-outstanding MMIO slave.
module clint
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1,
  parameter logic [63:0] HARTID   = 64'd0
) (
  input  logic    clk,
  input  logic    rst,
  clint_if.slave  bus,
  output logic    extint_software,
  output logic    extint_timer
);
  localparam logic [15:0] MSIP_OFF = CLINT_MSIP + 16'(HARTID << 2);
  localparam logic [15:0] CMP_OFF  = CLINT_MTIMECMP + 16'(HARTID << 3);

  state_e      state_q, state_d;
  logic [63:0] mtimecmp_q, mtimecmp_d, mtime, mtime_d, rdata_d, resp_rdata_q;
  logic        msip_q, msip_d, resp_err_q, err_d, ext_sw_q, ext_tmr_q;
  logic        acc, wr, sel_msip, sel_cmp, sel_time;
  logic        unused;

  assign unused = ^bus.req_addr[2:0];

  always_ff @(posedge clk) state_q <= rst ? ST_IDLE : state_d;

  always_comb
    state_d = state_q == ST_IDLE ? (bus.req_valid ? ST_RESP : ST_IDLE)
                                 : (bus.resp_ready ? ST_IDLE : ST_RESP);

  always_comb begin
    bus.req_ready  = state_q == ST_IDLE;
    bus.resp_valid = state_q == ST_RESP;
    bus.resp_rdata = resp_rdata_q;
    bus.resp_err   = resp_err_q;
  end

  // read data reflects register values before this cycle's tick or write
  always_comb begin
    acc        = state_q == ST_IDLE && bus.req_valid;
    wr         = acc && bus.req_wen;
    sel_msip   = bus.req_addr[15:3] == MSIP_OFF[15:3];
    sel_cmp    = bus.req_addr[15:3] == CMP_OFF[15:3];
    sel_time   = bus.req_addr[15:3] == CLINT_MTIME[15:3];
    msip_d     = wr && sel_msip && bus.req_wmask[0] ? bus.req_wdata[0] : msip_q;
    mtimecmp_d = wr && sel_cmp ? byte_merge(mtimecmp_q, bus.req_wdata, bus.req_wmask) : mtimecmp_q;
    rdata_d    = bus.req_wen ? '0 : sel_msip ? {63'b0, msip_q} : sel_cmp ? mtimecmp_q :
                 sel_time ? mtime : '0;
    err_d      = !(sel_msip || sel_cmp || sel_time);
  end

  clint_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .wr_i      (wr && sel_time),
    .wdata_i   (bus.req_wdata),
    .wmask_i   (bus.req_wmask),
    .mtime_o   (mtime),
    .mtime_d_o (mtime_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      msip_q       <= 1'b0;
      mtimecmp_q   <= MTIMECMP_RST;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      ext_sw_q     <= 1'b0;
      ext_tmr_q    <= 1'b0;
    end else begin
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      ext_sw_q   <= msip_d;
      ext_tmr_q  <= mtime_d >= mtimecmp_d;
      if (acc) begin
        resp_rdata_q <= rdata_d;
        resp_err_q   <= err_d;
      end
    end
  end

  assign extint_software = ext_sw_q;
  assign extint_timer    = ext_tmr_q;
endmodule

// File: tb/tb_clint.sv
// tb_clint: randomized scoreboard bench for clint against a register-level reference model.
module tb_clint;
  localparam int unsigned TD = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ext_sw, ext_tmr;
  always #5 clk = ~clk;

  clint_if bus();

  clint #(.TICK_DIV(TD), .HARTID(64'd0)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .extint_software (ext_sw),
    .extint_timer    (ext_tmr)
  );

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [63:0] m_time, m_cmp;
  logic m_msip, m_busy, m_acc;
  bit started = 0;
  longint unsigned m_edges;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d, input logic [7:0] m);
    logic [63:0] r;
    r = o;
    for (int i = 0; i < 8; i++)
      if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // reference model: applies one clock edge using the register-map rules
  task automatic model_step();
    logic        tick;
    logic [63:0] t;
    logic [15:0] a;
    exp_t        e;
    m_acc = 1'b0;
    if (rst) begin
      m_time = 64'd0; m_cmp = '1; m_msip = 1'b0; m_busy = 1'b0; m_edges = 0;
      q.delete();
      return;
    end
    tick = (m_edges % TD) == TD - 1;
    m_edges++;
    t = m_time + (tick ? 64'd1 : 64'd0);
    if (m_busy) begin
      if (bus.resp_ready) m_busy = 1'b0;
    end else if (bus.req_valid) begin
      m_acc = 1'b1;
      m_busy = 1'b1;
      a = bus.req_addr & 16'hFFF8;
      e.err = !(a == 16'h0000 || a == 16'h4000 || a == 16'hBFF8);
      e.rdata = bus.req_wen ? 64'd0 : a == 16'h0000 ? {63'd0, m_msip} : a == 16'h4000 ? m_cmp :
                a == 16'hBFF8 ? m_time : 64'd0;
      q.push_back(e);
      if (bus.req_wen) begin
        if (a == 16'h0000 && bus.req_wmask[0]) m_msip = bus.req_wdata[0];
        if (a == 16'h4000) m_cmp = merge(m_cmp, bus.req_wdata, bus.req_wmask);
        if (a == 16'hBFF8) t = merge(t, bus.req_wdata, bus.req_wmask);
      end
    end
    m_time = t;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    started = 1;
    #1;
  endtask

  task automatic txn(input logic [15:0] a, input logic w, input logic [63:0] d, input logic [7:0] m,
                     input int hold);
    bit ok = 0;
    bus.req_addr = a; bus.req_wen = w; bus.req_wdata = d; bus.req_wmask = m;
    bus.req_valid = 1'b1; bus.resp_ready = 1'b0;
    for (int g = 0; g < 20 && !ok; g++) begin
      tick();
      ok = m_acc;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout addr %h", a);
    end
    bus.req_valid = 1'b0;
    repeat (hold) tick();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  // monitor: compares DUT against the model and drains the scoreboard on handshake
  always @(negedge clk) begin
    if (started) begin
      chkb("req_ready", bus.req_ready, !m_busy);
      chkb("resp_valid", bus.resp_valid, m_busy);
      chkb("extint_software", ext_sw, m_msip);
      chkb("extint_timer", ext_tmr, m_time >= m_cmp);
      if (bus.resp_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_unexpected rdata %h", bus.resp_rdata);
        end else begin
          chk("resp_rdata", bus.resp_rdata, q[0].rdata);
          chkb("resp_err", bus.resp_err, q[0].err);
          if (bus.resp_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [15:0] a;
    logic [63:0] d;
    logic [7:0]  m;
    int sel;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_wmask = '0; bus.req_wen = 1'b0;
    bus.req_valid = 1'b0; bus.resp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
    txn(16'hBFF8, 1'b0, 64'd0, 8'h00, 0);
    txn(16'h4000, 1'b1, 64'd20, 8'hFF, 0);
    repeat (25) tick();
    txn(16'h4000, 1'b1, '1, 8'hFF, 1);
    txn(16'h0000, 1'b1, 64'd1, 8'hFF, 0);
    txn(16'h0000, 1'b0, 64'd0, 8'h00, 0);
    txn(16'h0000, 1'b1, 64'd0, 8'hFF, 0);
    txn(16'h0000, 1'b1, 64'hFFFF_FFFF, 8'hFF, 0);
    txn(16'h0004, 1'b0, 64'd0, 8'h00, 2);
    txn(16'hBFF8, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0);
    txn(16'hBFF8, 1'b0, 64'd0, 8'h00, 0);
    txn(16'hBFF8, 1'b1, 64'h55, 8'h01, 0);
    txn(16'hBFF8, 1'b0, 64'd0, 8'h00, 0);
    txn(16'h0000, 1'b1, 64'd0, 8'h00, 0);
    txn(16'h1234, 1'b0, 64'd0, 8'h00, 10);
    txn(16'h1234, 1'b1, '1, 8'hFF, 1);
    for (int n = 0; n < 250; n++) begin
      sel = $urandom_range(0, 4);
      a = sel == 0 ? 16'h0000 : sel == 2 ? 16'hBFF8 : sel == 3 ? 16'($urandom) : 16'h4000;
      a = a | 16'($urandom_range(0, 7));
      d = {$urandom, $urandom};
      m = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'hFF;
      if (sel == 1 || sel == 4) d = m_time + 64'($urandom_range(0, 40));
      if (sel == 2 && $urandom_range(0, 1) == 1) d = m_time - 64'($urandom_range(0, 30));
      txn(a, 1'($urandom_range(0, 1)), d, m, $urandom_range(0, 3));
      repeat ($urandom_range(0, 5)) tick();
    end
    bus.req_addr = 16'h4000; bus.req_wen = 1'b1; bus.req_wdata = 64'd5; bus.req_wmask = 8'hFF;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    txn(16'h4000, 1'b0, 64'd0, 8'h00, 0);
    txn(16'hBFF8, 1'b0, 64'd0, 8'h00, 0);
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
